// File: rtl/sram_32x128_1rw_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the 32x128 single-port SRAM model:
//   - default geometry (DATA_WIDTH, ADDR_WIDTH) and the derived RAM_DEPTH
//   - data/address typedefs used by the interface, the array and benches
//   - a small access-decode helper turning the active-low strobes into an
//     explicit operation code
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 7;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Operation performed on a rising edge of the clock.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } op_e;

    // Both strobes are active low: deselect wins over the write enable.
    function automatic op_e decode_op(input logic csb, input logic web);
        if (csb) begin
            return OP_IDLE;
        end else if (web) begin
            return OP_READ;
        end else begin
            return OP_WRITE;
        end
    endfunction

endpackage : sram_pkg

// File: rtl/sram_32x128_1rw_if.sv
// ---------------------------------------------------------------------------
// sram_32x128_1rw_if
// Bundles the single shared read/write port of the SRAM.
//   csb0        chip select, active low          (master -> slave)
//   web0        write enable, active low         (master -> slave)
//   addr0       word address                     (master -> slave)
//   din0        write data                       (master -> slave)
//   dout0       registered read data             (slave  -> master)
//   parity_err0 registered parity mismatch flag  (slave  -> master)
//               present only when SRAM_PARITY_EN is defined
// Modports: master (core / bus adapter side), slave (memory side).
// ---------------------------------------------------------------------------
interface sram_32x128_1rw_if #(
    parameter int DATA_WIDTH = sram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sram_pkg::ADDR_WIDTH
);

    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
`ifdef SRAM_PARITY_EN
    logic                  parity_err0;
`endif

`ifdef SRAM_PARITY_EN
    modport master (
        output csb0, web0, addr0, din0,
        input  dout0, parity_err0
    );

    modport slave (
        input  csb0, web0, addr0, din0,
        output dout0, parity_err0
    );
`else
    modport master (
        output csb0, web0, addr0, din0,
        input  dout0
    );

    modport slave (
        input  csb0, web0, addr0, din0,
        output dout0
    );
`endif

endinterface : sram_32x128_1rw_if

// File: rtl/sram_32x128_1rw_parity_gen.sv
// ---------------------------------------------------------------------------
// sram_parity_gen
// Combinational even-parity generator. The returned bit makes the total
// number of ones across {data_i, parity_o} even. The same block computes
// the bit stored on a write and the bit recomputed on a read, so both
// paths agree on the parity definition by construction.
//   data_i   in  WIDTH  word to protect
//   parity_o out 1      XOR reduction of data_i
// ---------------------------------------------------------------------------
module sram_parity_gen #(
    parameter int WIDTH = sram_pkg::DATA_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    assign parity_o = ^data_i;

endmodule : sram_parity_gen

// File: rtl/sram_32x128_1rw.sv
// ---------------------------------------------------------------------------
// sram_32x128_1rw
// Functional model of a single-port synchronous 32-bit x 128-word SRAM.
// One shared port: per rising edge of clk0 it performs an idle cycle, a
// write, or a read with one cycle of latency. Read data is registered and
// holds until the next read; writes never update dout0.
//
// Ports:
//   clk0   in   1      clock, all state changes on its rising edge
//   rst_n  in   1      asynchronous active-low reset, clears dout0 only
//   bus    slave       csb0 / web0 / addr0 / din0 in, dout0 out
//                      (plus parity_err0 out with SRAM_PARITY_EN)
//
// Configuration macro:
//   SRAM_PARITY_EN  when defined, each word carries an even-parity bit
//                   written from din0, and a read reports a mismatch
//                   between recomputed and stored parity on parity_err0.
//                   When undefined there is no parity storage at all.
// ---------------------------------------------------------------------------
module sram_32x128_1rw #(
    parameter int DATA_WIDTH = sram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sram_pkg::ADDR_WIDTH
) (
    input  logic              clk0,
    input  logic              rst_n,
    sram_32x128_1rw_if.slave  bus
);

    import sram_pkg::*;

    // Depth always follows the address width; every address is in range.
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    // -----------------------------------------------------------------------
    // Access decode
    // -----------------------------------------------------------------------
    op_e op;

    assign op = decode_op(bus.csb0, bus.web0);

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    // NOTE: the array has no reset branch on purpose: a real macro powers up
    // with unknown contents, and a reset loop over every word would stop the
    // array mapping onto RAM.
    // NOTE: sequential state is always updated with non-blocking <= so every
    // flop samples the values that existed before the edge.
    always_ff @(posedge clk0) begin
        if (op == OP_WRITE) begin
            mem[bus.addr0] <= bus.din0;
        end
    end

    // -----------------------------------------------------------------------
    // Registered read port
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    // NOTE: the hold value is assigned first so every path through the block
    // drives dout_d, which keeps this purely combinational (no latch).
    always_comb begin
        dout_d = dout_q;
        if (op == OP_READ) begin
            dout_d = mem[bus.addr0];
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.dout0 = dout_q;

`ifdef SRAM_PARITY_EN
    // -----------------------------------------------------------------------
    // Parity storage and check
    // -----------------------------------------------------------------------
    // Kept as a separate bit array beside the data so a bench can disturb the
    // stored parity without touching the data word.
    logic par_mem [RAM_DEPTH];

    logic wr_parity;   // parity of incoming din0
    logic rd_parity;   // parity recomputed from the addressed word

    sram_parity_gen #(
        .WIDTH (DATA_WIDTH)
    ) u_wr_parity (
        .data_i   (bus.din0),
        .parity_o (wr_parity)
    );

    sram_parity_gen #(
        .WIDTH (DATA_WIDTH)
    ) u_rd_parity (
        .data_i   (mem[bus.addr0]),
        .parity_o (rd_parity)
    );

    always_ff @(posedge clk0) begin
        if (op == OP_WRITE) begin
            par_mem[bus.addr0] <= wr_parity;
        end
    end

    logic parity_err_d;
    logic parity_err_q;

    // The flag is produced on the same edge as the read data and, like
    // dout0, holds between reads.
    always_comb begin
        parity_err_d = parity_err_q;
        if (op == OP_READ) begin
            parity_err_d = rd_parity ^ par_mem[bus.addr0];
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err0 = parity_err_q;
`endif

endmodule : sram_32x128_1rw

// File: tb/tb_sram_32x128_1rw.sv
// ---------------------------------------------------------------------------
// tb_sram_32x128_1rw
// Self-checking bench for sram_32x128_1rw. Inputs change on the falling edge
// of clk0; outputs are sampled 1 time unit after the rising edge. A plain
// array of words plus an "expected dout" variable model the memory: writes
// store, reads copy the stored word into the expected output, everything
// else leaves the expected output alone.
// ---------------------------------------------------------------------------
module tb_sram_32x128_1rw;

    import sram_pkg::*;

    logic clk0  = 1'b0;
    logic rst_n = 1'b0;

    sram_32x128_1rw_if bus ();

    sram_32x128_1rw dut (
        .clk0  (clk0),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk0 = ~clk0;

    int n_checks = 0;
    int n_errors = 0;

    data_t model_mem [RAM_DEPTH];
    data_t exp_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_write(input addr_t a, input data_t d);
        @(negedge clk0);
        bus.csb0  = 1'b0;
        bus.web0  = 1'b0;
        bus.addr0 = a;
        bus.din0  = d;
        @(posedge clk0);
        #1;
        model_mem[a] = d;
        check("write_holds_dout", bus.dout0, exp_dout);
    endtask

    task automatic do_read(input string tag, input addr_t a);
        @(negedge clk0);
        bus.csb0  = 1'b0;
        bus.web0  = 1'b1;
        bus.addr0 = a;
        bus.din0  = data_t'($urandom());
        @(posedge clk0);
        #1;
        exp_dout = model_mem[a];
        check(tag, bus.dout0, exp_dout);
    endtask

    // Deselected cycle with arbitrary strobes and data on the bus.
    task automatic do_idle(input logic web, input addr_t a, input data_t d);
        @(negedge clk0);
        bus.csb0  = 1'b1;
        bus.web0  = web;
        bus.addr0 = a;
        bus.din0  = d;
        @(posedge clk0);
        #1;
        check("idle_holds_dout", bus.dout0, exp_dout);
    endtask

    // Bound the run even if something upstream stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wide_addr;
        addr_t      trunc_addr;

        bus.csb0  = 1'b1;
        bus.web0  = 1'b1;
        bus.addr0 = '0;
        bus.din0  = '0;
        exp_dout  = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk0);
        #1;
        check("reset_dout", bus.dout0, 32'h0);
        @(negedge clk0);
        rst_n = 1'b1;
        do_idle(1'b1, 7'd0, 32'h0);

        // ---------------- basic write/read ----------------
        do_write(7'd10, 32'hFACE_CAFE);
        do_read("basic_read", 7'd10);
        do_idle(1'b1, 7'd3, 32'h0);
        check("basic_hold", bus.dout0, 32'hFACE_CAFE);

        // ---------------- fill / readback ----------------
        for (int i = 0; i < RAM_DEPTH; i++) begin
            if (i < 32) do_write(addr_t'(i), data_t'(i));
            else        do_write(addr_t'(i), data_t'(32'hFFFF_FFFF - i));
        end
        for (int i = 0; i < RAM_DEPTH; i++) begin
            do_read("fill_read", addr_t'(i));
        end

        // ---------------- read-after-write, next cycle ----------------
        do_write(7'd77, 32'h1234_5678);
        do_read("raw_next_cycle", 7'd77);
        do_write(7'd0, 32'hDEAD_BEEF);
        do_read("raw_addr0", 7'd0);
        do_write(7'd127, 32'h8000_0001);
        do_read("raw_addr127", 7'd127);

        // Restore the fill pattern for the stress section.
        do_write(7'd0, 32'h0);

        // ---------------- truncated address + repeated reads ----------------
        wide_addr  = 8'hAA;
        trunc_addr = wide_addr[6:0];
        check("trunc_addr", 32'(trunc_addr), 32'h2A);
        do_write(trunc_addr, 32'hA5A5_002A);
        for (int k = 0; k < 35; k++) begin
            do_read("repeat_read_2a", trunc_addr);
        end
        for (int i = 0; i < 32; i++) begin
            do_read("post_repeat_read", addr_t'(i));
        end

        // ---------------- chip deselect ----------------
        do_read("deselect_pre", 7'd20);
        do_idle(1'b0, 7'd20, 32'h5555_AAAA);
        do_idle(1'b0, 7'd21, 32'hFFFF_0000);
        do_idle(1'b1, 7'd22, 32'h0F0F_0F0F);
        do_read("deselect_addr20", 7'd20);
        do_read("deselect_addr21", 7'd21);

        // ---------------- asynchronous reset mid-run ----------------
        do_read("pre_reset_read", 7'd50);
        #2;
        rst_n = 1'b0;
        #1;
        exp_dout = '0;
        check("async_reset_dout", bus.dout0, 32'h0);
        // A read request during reset must not reach dout0.
        @(negedge clk0);
        bus.csb0  = 1'b0;
        bus.web0  = 1'b1;
        bus.addr0 = 7'd50;
        @(posedge clk0);
        #1;
        check("reset_blocks_read", bus.dout0, 32'h0);
        @(negedge clk0);
        rst_n = 1'b1;
        // First edge after release performs the pending read normally.
        @(posedge clk0);
        #1;
        exp_dout = model_mem[50];
        check("first_edge_after_reset", bus.dout0, exp_dout);
        do_read("post_reset_read", 7'd99);

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            addr_t       ra;
            sel = $urandom_range(0, 9);
            ra  = addr_t'($urandom_range(0, RAM_DEPTH - 1));
            if (sel < 4)      do_write(ra, data_t'($urandom()));
            else if (sel < 8) do_read("random_read", ra);
            else              do_idle(1'($urandom_range(0, 1)), ra, data_t'($urandom()));
        end
        for (int i = 0; i < RAM_DEPTH; i++) begin
            do_read("final_sweep", addr_t'(i));
        end

`ifdef SRAM_PARITY_EN
        // ---------------- parity ----------------
        do_write(7'd5, 32'h0000_0001);
        do_read("parity_data", 7'd5);
        check("parity_clean", 32'(bus.parity_err0), 32'h0);
        dut.par_mem[5] = ~dut.par_mem[5];
        do_read("parity_bad_data", 7'd5);
        check("parity_error", 32'(bus.parity_err0), 32'h1);
        do_idle(1'b1, 7'd5, 32'h0);
        check("parity_hold", 32'(bus.parity_err0), 32'h1);
        do_read("parity_other", 7'd6);
        check("parity_other_clean", 32'(bus.parity_err0), 32'h0);
        do_read("parity_bad_again", 7'd5);
        #2;
        rst_n = 1'b0;
        #1;
        exp_dout = '0;
        check("parity_reset", 32'(bus.parity_err0), 32'h0);
        @(negedge clk0);
        bus.csb0 = 1'b1;
        rst_n    = 1'b1;
        do_write(7'd5, 32'h0000_0003);
        do_read("parity_rewrite", 7'd5);
        check("parity_rewrite_clean", 32'(bus.parity_err0), 32'h0);
`endif

        @(negedge clk0);
        bus.csb0 = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sram_32x128_1rw
